// File: rtl/req_ack_if.sv
// Request/acknowledge tracker bus: per-channel request pulses in, acks, counters and flags out.
// Counter and in-flight vectors are flat, channel i at [i*W +: W].
interface req_ack_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 32,
    parameter int OUT_W    = 3
);
    logic [CHANNELS-1:0]       req;
    logic [CHANNELS-1:0]       clr_err;
    logic [CHANNELS-1:0]       ack;
    logic [CHANNELS*CNT_W-1:0] req_cnt;
    logic [CHANNELS*CNT_W-1:0] ack_cnt;
    logic [CHANNELS*OUT_W-1:0] in_flight;
    logic [CHANNELS-1:0]       gap_err;

    modport master (
        output req, clr_err,
        input  ack, req_cnt, ack_cnt, in_flight, gap_err
    );

    modport slave (
        input  req, clr_err,
        output ack, req_cnt, ack_cnt, in_flight, gap_err
    );
endinterface

// File: rtl/req_ack_tracker.sv
// Multi-channel req/ack responder: spacing-checked accepts, fixed-latency acks,
// per-channel wrap-around counters, in-flight count and sticky spacing error.
module req_ack_chan #(
    parameter int LATENCY = 4,
    parameter int MIN_GAP = 8,
    parameter int CNT_W   = 32,
    parameter int OUT_W   = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             clr_err,
    output logic             ack,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] ack_cnt,
    output logic [OUT_W-1:0] in_flight,
    output logic             gap_err
);
    localparam int               GAP_W   = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MIN_GAP);

    logic [GAP_W-1:0] gap_cnt;
    logic [LATENCY:1] vld_pipe;
    logic             accept;

    // Saturated spacing counter means MIN_GAP cycles have passed since the last accept.
    assign accept = req && (gap_cnt == GAP_SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= GAP_SAT;
        end else if (accept) begin
            gap_cnt <= GAP_W'(1);
        end else if (gap_cnt != GAP_SAT) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= accept;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign ack = vld_pipe[LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt <= '0;
            ack_cnt <= '0;
        end else begin
            if (accept) req_cnt <= req_cnt + CNT_W'(1);
            if (ack)    ack_cnt <= ack_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({accept, ack})
                2'b10:   in_flight <= in_flight + OUT_W'(1);
                2'b01:   in_flight <= in_flight - OUT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    // A violation in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_err <= 1'b0;
        end else if (req && !accept) begin
            gap_err <= 1'b1;
        end else if (clr_err) begin
            gap_err <= 1'b0;
        end
    end
endmodule

module req_ack_tracker #(
    parameter int CHANNELS = 2,
    parameter int LATENCY  = 4,
    parameter int MIN_GAP  = 8,
    parameter int CNT_W    = 32,
    parameter int OUT_W    = $clog2(LATENCY + 1)
) (
    input  logic     clk,
    input  logic     rst_n,
    req_ack_if.slave bus
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        req_ack_chan #(
            .LATENCY (LATENCY),
            .MIN_GAP (MIN_GAP),
            .CNT_W   (CNT_W),
            .OUT_W   (OUT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (bus.req[g]),
            .clr_err   (bus.clr_err[g]),
            .ack       (bus.ack[g]),
            .req_cnt   (bus.req_cnt[g*CNT_W +: CNT_W]),
            .ack_cnt   (bus.ack_cnt[g*CNT_W +: CNT_W]),
            .in_flight (bus.in_flight[g*OUT_W +: OUT_W]),
            .gap_err   (bus.gap_err[g])
        );
    end
endmodule

// File: tb/tb_req_ack_tracker.sv
// Directed bench for req_ack_tracker: default, short-gap/long-latency and narrow-counter builds.
module tb_req_ack_tracker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_n;
    int   cyc;
    int   n_chk  = 0;
    int   n_fail = 0;

    req_ack_if #(.CHANNELS(2), .CNT_W(32), .OUT_W(3)) ia ();
    req_ack_if #(.CHANNELS(2), .CNT_W(32), .OUT_W(3)) ib ();
    req_ack_if #(.CHANNELS(2), .CNT_W(3),  .OUT_W(3)) ic ();

    req_ack_tracker #(.CHANNELS(2), .LATENCY(4), .MIN_GAP(8), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_a), .bus(ia));
    req_ack_tracker #(.CHANNELS(2), .LATENCY(6), .MIN_GAP(2), .CNT_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));
    req_ack_tracker #(.CHANNELS(2), .LATENCY(4), .MIN_GAP(8), .CNT_W(3)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ic));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        ia.req = '0; ia.clr_err = '0;
        ib.req = '0; ib.clr_err = '0;
        ic.req = '0; ic.clr_err = '0;
    endtask

    // Inputs change 1ns after the edge; the interval up to the next edge is cycle cyc.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        clear_pulses();
    endtask

    task automatic do_reset();
        rst_a = 1'b0;
        rst_n = 1'b0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        clear_pulses();
        do_reset();

        // reset state
        chk("rst_ack",      ia.ack,              32'd0);
        chk("rst_req_cnt0", ia.req_cnt[31:0],    32'd0);
        chk("rst_req_cnt1", ia.req_cnt[63:32],   32'd0);
        chk("rst_ack_cnt0", ia.ack_cnt[31:0],    32'd0);
        chk("rst_inflight", ia.in_flight,        32'd0);
        chk("rst_gap_err",  ia.gap_err,          32'd0);

        // legal spacing: reqs at 2 and 10, acks at 6 and 14
        for (int t = 0; t <= 15; t++) begin
            if (t == 2 || t == 10) ia.req[0] = 1'b1;
            chk($sformatf("s1_ack0@%0d", t), ia.ack[0], (t == 6 || t == 14));
            tick();
        end
        chk("s1_req_cnt0",  ia.req_cnt[31:0],  32'd2);
        chk("s1_ack_cnt0",  ia.ack_cnt[31:0],  32'd2);
        chk("s1_inflight0", ia.in_flight[2:0], 32'd0);
        chk("s1_gap_err",   ia.gap_err,        32'd0);

        // dropped req, clear, then violation colliding with a clear
        do_reset();
        for (int t = 0; t <= 16; t++) begin
            if (t == 2 || t == 5 || t == 11 || t == 12 || t == 14) ia.req[0] = 1'b1;
            if (t == 8 || t == 14 || t == 15) ia.clr_err[0] = 1'b1;
            chk($sformatf("s2_ack0@%0d", t), ia.ack[0], (t == 6 || t == 15));
            chk($sformatf("s2_gap0@%0d", t), ia.gap_err[0],
                ((t >= 6 && t <= 8) || (t >= 13 && t <= 15)));
            if (t == 10) chk("s2_req_cnt0@10", ia.req_cnt[31:0], 32'd1);
            tick();
        end
        chk("s2_req_cnt0",  ia.req_cnt[31:0],  32'd2);
        chk("s2_ack_cnt0",  ia.ack_cnt[31:0],  32'd2);
        chk("s2_inflight0", ia.in_flight[2:0], 32'd0);

        // overlapping in-flight reqs on channel 1 of the LATENCY=6, MIN_GAP=2 build
        do_reset();
        for (int t = 0; t <= 12; t++) begin
            logic [31:0] fl;
            if (t == 0 || t == 2 || t == 4) ib.req[1] = 1'b1;
            fl = (t < 1) ? 0 : (t < 3) ? 1 : (t < 5) ? 2 : (t < 7) ? 3 :
                 (t < 9) ? 2 : (t < 11) ? 1 : 0;
            chk($sformatf("s3_ack1@%0d", t),  ib.ack[1], (t == 6 || t == 8 || t == 10));
            chk($sformatf("s3_fl1@%0d", t),   ib.in_flight[5:3], fl);
            chk($sformatf("s3_ack0@%0d", t),  ib.ack[0], 32'd0);
            chk($sformatf("s3_fl0@%0d", t),   ib.in_flight[2:0], 32'd0);
            tick();
        end
        chk("s3_req_cnt1", ib.req_cnt[63:32], 32'd3);
        chk("s3_ack_cnt1", ib.ack_cnt[63:32], 32'd3);
        chk("s3_req_cnt0", ib.req_cnt[31:0],  32'd0);
        chk("s3_gap_err",  ib.gap_err,        32'd0);

        // reset mid-flight discards the pending ack
        do_reset();
        for (int t = 0; t <= 12; t++) begin
            if (t == 3 || t == 7) ia.req[0] = 1'b1;
            if (t == 5) rst_a = 1'b0;
            if (t == 6) rst_a = 1'b1;
            #1;
            chk($sformatf("s4_ack0@%0d", t), ia.ack[0], (t == 11));
            if (t == 4) begin
                chk("s4_req_cnt0@4",  ia.req_cnt[31:0],  32'd1);
                chk("s4_inflight0@4", ia.in_flight[2:0], 32'd1);
            end
            if (t == 5) begin
                chk("s4_req_cnt0@5",  ia.req_cnt[31:0],  32'd0);
                chk("s4_ack_cnt0@5",  ia.ack_cnt[31:0],  32'd0);
                chk("s4_inflight0@5", ia.in_flight[2:0], 32'd0);
            end
            tick();
        end
        chk("s4_req_cnt0",  ia.req_cnt[31:0],  32'd1);
        chk("s4_ack_cnt0",  ia.ack_cnt[31:0],  32'd1);
        chk("s4_inflight0", ia.in_flight[2:0], 32'd0);

        // 3-bit counters wrap after 9 spaced reqs
        do_reset();
        for (int t = 0; t <= 69; t++) begin
            if (t % 8 == 0 && t <= 64) ic.req[0] = 1'b1;
            if (t == 57) begin
                chk("s5_req_cnt0@57", ic.req_cnt[2:0], 32'd0);
                chk("s5_ack_cnt0@57", ic.ack_cnt[2:0], 32'd7);
            end
            if (t == 68) chk("s5_ack0@68", ic.ack[0], 32'd1);
            tick();
        end
        chk("s5_req_cnt0", ic.req_cnt[2:0], 32'd1);
        chk("s5_ack_cnt0", ic.ack_cnt[2:0], 32'd1);
        chk("s5_gap_err",  ic.gap_err,      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/req_ack_tracker.md
# req_ack_tracker

Multi-channel request/acknowledge responder and tracker for the staged simulation/verification test designs. Each channel accepts single-cycle request pulses, enforces a minimum request spacing, and returns a single-cycle acknowledge a fixed number of cycles later. Per-channel request/acknowledge counters and an in-flight count are exported so staged cover and assert properties can target exact progress points. This block is the parametrised successor of the fixed single-channel, 4-cycle, 8-cycle-spacing handshake.

## Interface
- CHANNELS, 2, number of independent req/ack channels (≥1)
- LATENCY, 4, cycles from accepted req to ack (≥1)
- MIN_GAP, 8, minimum cycles between accepted reqs on one channel (≥1; MIN_GAP < LATENCY allowed, so overlapping in-flight reqs are legal)
- CNT_W, 32, width of each counter
- OUT_W, $clog2(LATENCY+1), width of each in-flight count

- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  CHANNELS  per-channel request pulse
- clr_err  in  CHANNELS  per-channel clear of sticky gap_err
- ack  out  CHANNELS  per-channel acknowledge pulse, registered
- req_cnt  out  CHANNELS*CNT_W  accepted reqs per channel; channel i at [i*CNT_W +: CNT_W]
- ack_cnt  out  CHANNELS*CNT_W  acks issued per channel, same packing
- in_flight  out  CHANNELS*OUT_W  accepted reqs not yet acked, per channel
- gap_err  out  CHANNELS  sticky spacing-violation flag

## Operation
- Channels are fully independent; there is no shared state.
- Accept rule: req[i] high in cycle t is accepted if channel i has had no accepted req since reset, or the last accepted req was at cycle ≤ t−MIN_GAP. Otherwise it is dropped.
- Dropped req: no ack, no req_cnt increment. gap_err[i] is set.
- Spacing counter per channel:
  - loads 1 on accept, increments each cycle, saturates at MIN_GAP.
  - resets to "saturated" (accept allowed).
  - Dropped reqs do not reload it.
- Ack generation: per-channel LATENCY-deep shift line of accept bits; ack[i] = tap LATENCY. Multiple in-flight reqs are tracked independently.
- req_cnt[i] increments on accept. ack_cnt[i] increments on each ack[i] cycle. Both wrap modulo 2^CNT_W.
- in_flight[i]: +1 on accept, −1 on ack, unchanged when both occur in the same cycle. It never exceeds ceil(LATENCY/MIN_GAP).
- gap_err[i]:
  - set on a dropped req.
  - cleared by clr_err[i].
  - if set and clear occur in the same cycle, set wins.
- req held high for several cycles: the first cycle is accepted if legal; each later cycle within MIN_GAP is a violation.

## Timing
- Reset values (asynchronous): ack=0, req_cnt=0, ack_cnt=0, in_flight=0, gap_err=0, shift lines cleared, spacing counters saturated.
- Reset asserted mid-operation discards all in-flight reqs; no ack is emitted for them after release.
- Accepted req in cycle t → ack[i] high exactly in cycle t+LATENCY, for exactly one cycle.
- req_cnt and in_flight reflect an accept in cycle t+1. ack_cnt reflects an ack in cycle t+LATENCY+1.
- A dropped req in cycle t → gap_err high from cycle t+1.
- With MIN_GAP ≥ LATENCY+1, ack never overlaps a new accept on the same channel. With smaller MIN_GAP, an ack and a new accept in the same cycle are both honoured.
- No combinational path from any input to any output.

## Test plan
- Defaults, req[0] at cycles 2 and 10 → ack[0] at cycles 6 and 14 only; after cycle 15, req_cnt[0]=2, ack_cnt[0]=2, in_flight[0]=0; gap_err=0.
- Defaults, req[0] at cycles 2 and 5 → second req dropped; ack[0] only at 6; req_cnt[0]=1; gap_err[0] high from cycle 6. clr_err[0] at cycle 8 → gap_err[0]=0 at cycle 9.
- LATENCY=6, MIN_GAP=2, req[1] at cycles 0, 2, 4 → ack[1] at 6, 8, 10; in_flight[1] peaks at 3; channel 0 unaffected.
- Defaults, req[0] at cycle 3, rst_n low at cycle 5 and released at 6 → no ack at 7; all counters 0; req at cycle 7 accepted and acked at 11.
- CNT_W=3, req[0] every 8 cycles, 9 times → req_cnt[0] wraps to 1 and ack_cnt[0] to 1 after the final ack.
- Simultaneous clr_err[0] and violating req[0] in the same cycle → gap_err[0] remains 1.
